vga_sync_decoder: RTL
=====================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_TOTAL, 800, pixel ticks per line.
- V_TOTAL, 525, lines per frame.
- H_DISPLAY, 640, visible pixels per line.
- V_DISPLAY, 480, visible lines per frame.
- H_SYNC_LOAD, 657, x value assigned on the tick where an hsync_in rise is detected.
- V_SYNC_LOAD, 513, y value assigned on the tick where a vsync_in rise is detected.
- LOCK_LINES, 4, consecutive consistent lines needed before LOCKED.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous, active-high.
- p_tick, in, 1, pixel-rate enable, one clk wide.
- hsync_in, in, 1, horizontal sync, high during retrace.
- vsync_in, in, 1, vertical sync, high during retrace.
- x, out, 10, recovered horizontal position.
- y, out, 10, recovered vertical position.
- video_on, out, 1, locked and inside the visible area.
- locked, out, 1, decoder locked to the incoming timing.
- frame_start, out, 1, one-clk pulse at the frame origin.
- sync_err, out, 1, one-clk pulse on a timing violation.

Function
REQ-003 All state SHALL update only on clk cycles with p_tick=1, except the frame_start and sync_err pulses, which SHALL clear on the next clk.
REQ-004 hs_q and vs_q SHALL sample hsync_in and vsync_in on each p_tick.
REQ-005 An hsync rise SHALL be hsync_in=1 with hs_q=0 on a p_tick; a vsync rise is defined the same way using vs_q.
REQ-006 Free-running counting: x increments on each p_tick and wraps from H_TOTAL-1 to 0. When x wraps, y increments and wraps from V_TOTAL-1 to 0.
REQ-007 On an hsync rise, x SHALL load H_SYNC_LOAD.
- The rise is consistent if pre-load x equals H_SYNC_LOAD-1.
- Otherwise it is inconsistent.
REQ-008 On a vsync rise, y SHALL load V_SYNC_LOAD, overriding any increment on the same tick.
- The rise is consistent if pre-update y equals V_SYNC_LOAD.
REQ-009 FSM states are HUNT, H_LOCK and LOCKED.
- Reset state: HUNT.
- locked=1 only in LOCKED.
REQ-010 HUNT: the first hsync rise SHALL move to H_LOCK with good_cnt=0.
REQ-011 H_LOCK, hsync rises:
- Consistent rise: good_cnt increments, saturating at 15.
- Inconsistent rise: good_cnt resets to 0.
REQ-012 H_LOCK, vsync rise:
- good_cnt >= LOCK_LINES: move to LOCKED.
- Otherwise: remain in H_LOCK; y is still loaded.
REQ-013 LOCKED, hsync rises:
- Inconsistent rise: miss_cnt increments and sync_err pulses.
- Consistent rise: miss_cnt clears.
- miss_cnt reaching 2 (two consecutive inconsistent lines) SHALL move to HUNT.
REQ-014 LOCKED, inconsistent vsync rise: sync_err pulses and the FSM moves to HUNT.
REQ-015 Watchdog: in H_LOCK or LOCKED, H_TOTAL+8 consecutive p_ticks without an hsync rise SHALL move to HUNT and pulse sync_err.
REQ-016 Same-tick hsync and vsync rises SHALL both be processed in that tick: x loads, y loads, and both checks apply. Any HUNT transition takes priority over LOCKED.
REQ-017 Outputs:
- video_on = locked && x<H_DISPLAY && y<V_DISPLAY, registered with x and y.
- x and y continue counting in every state.
REQ-018 frame_start SHALL pulse for one clk when x and y both wrap to 0 while in LOCKED.

Reset
REQ-019 While reset=1 and on release:
- x=0, y=0, hs_q=0, vs_q=0.
- good_cnt=0, miss_cnt=0, watchdog=0.
- State HUNT; locked=0, video_on=0, frame_start=0, sync_err=0.
REQ-020 Reset asserted mid-frame SHALL take effect immediately. After release, relock requires the full HUNT to H_LOCK to LOCKED sequence.

Verification
REQ-021 Ideal 800x525 sync stream (hsync rising 1 tick after x=656, vsync rise at y=513) -> locked=1 at the first vsync rise following 4 consistent lines; afterwards x/y track the stream exactly, with no sync_err.
REQ-022 Locked, then one hsync rise shifted +3 ticks -> one sync_err pulse, locked stays 1, x realigns to 657 on that tick; a second consecutive shifted line -> HUNT, locked=0.
REQ-023 Locked, then hsync_in held low for 808 ticks -> sync_err pulse, locked=0, video_on=0.
REQ-024 Locked, then vsync rise arriving with y=400 -> sync_err, HUNT, y=513.
REQ-025 Reset pulsed at x=300, y=200 while locked -> all outputs 0 immediately; relock needs at least 4 lines plus a vsync rise.
REQ-026 Hsync and vsync rising on the same tick in H_LOCK with good_cnt=5 -> LOCKED, x=657, y=513; frame_start pulses exactly once per 420000 p_ticks thereafter.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - recovers x/y position and lock status from an incoming hsync/vsync stream
// Free-running counters re-aligned by sync rises, with a HUNT/H_LOCK/LOCKED lock qualifier.
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_DISPLAY   = 640,
  parameter int V_DISPLAY   = 480,
  parameter int H_SYNC_LOAD = 657,
  parameter int V_SYNC_LOAD = 513,
  parameter int LOCK_LINES  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       locked,
  output logic       frame_start,
  output logic       sync_err
);

  localparam int WD_W = $clog2(H_TOTAL + 9);

  typedef enum logic [1:0] {HUNT, H_LOCK, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [9:0]      x_q, x_d, y_q, y_d;
  logic            hs_q, hs_d, vs_q, vs_d;
  logic [3:0]      good_cnt_q, good_cnt_d;
  logic [1:0]      miss_cnt_q, miss_cnt_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            video_on_q, video_on_d;
  logic            frame_start_q, frame_start_d;
  logic            sync_err_q, sync_err_d;
  logic            go_hunt;

  logic h_rise, v_rise, h_ok, v_ok, x_wrap, y_wrap, wd_expire;

  assign h_rise    = p_tick & hsync_in & ~hs_q;
  assign v_rise    = p_tick & vsync_in & ~vs_q;
  assign h_ok      = (x_q == 10'(H_SYNC_LOAD - 1));
  assign v_ok      = (y_q == 10'(V_SYNC_LOAD));
  assign x_wrap    = (x_q == 10'(H_TOTAL - 1));
  assign y_wrap    = (y_q == 10'(V_TOTAL - 1));
  // Fires on the H_TOTAL+8'th consecutive tick without an hsync rise.
  assign wd_expire = (state_q != HUNT) && !h_rise && (wd_q == WD_W'(H_TOTAL + 7));

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    good_cnt_d    = good_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    wd_d          = wd_q;
    video_on_d    = video_on_q;
    frame_start_d = 1'b0;
    sync_err_d    = 1'b0;
    go_hunt       = 1'b0;

    if (p_tick) begin
      hs_d = hsync_in;
      vs_d = vsync_in;

      if (h_rise)      x_d = 10'(H_SYNC_LOAD);
      else if (x_wrap) x_d = 10'd0;
      else             x_d = x_q + 1'b1;

      if (v_rise)                 y_d = 10'(V_SYNC_LOAD);
      else if (!h_rise && x_wrap) y_d = y_wrap ? 10'd0 : y_q + 1'b1;

      wd_d = (h_rise || state_q == HUNT) ? '0 : wd_q + 1'b1;

      case (state_q)
        HUNT: begin
          if (h_rise) begin
            state_d    = H_LOCK;
            good_cnt_d = 4'd0;
          end
        end
        H_LOCK: begin
          if (h_rise)
            good_cnt_d = h_ok ? ((good_cnt_q == 4'd15) ? 4'd15 : good_cnt_q + 1'b1) : 4'd0;
          if (v_rise && good_cnt_q >= 4'(LOCK_LINES)) begin
            state_d    = LOCKED;
            miss_cnt_d = 2'd0;
          end
        end
        LOCKED: begin
          if (h_rise) begin
            if (h_ok) begin
              miss_cnt_d = 2'd0;
            end else begin
              sync_err_d = 1'b1;
              miss_cnt_d = miss_cnt_q + 1'b1;
              if (miss_cnt_q == 2'd1) go_hunt = 1'b1;
            end
          end
          if (v_rise && !v_ok) begin
            sync_err_d = 1'b1;
            go_hunt    = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase

      if (wd_expire) begin
        sync_err_d = 1'b1;
        go_hunt    = 1'b1;
      end

      // Losing lock overrides any other transition taken on this tick.
      if (go_hunt) begin
        state_d    = HUNT;
        good_cnt_d = 4'd0;
        miss_cnt_d = 2'd0;
        wd_d       = '0;
      end

      frame_start_d = (state_q == LOCKED) && !go_hunt && !h_rise && !v_rise && x_wrap && y_wrap;
      video_on_d    = (state_d == LOCKED) && (x_d < 10'(H_DISPLAY)) && (y_d < 10'(V_DISPLAY));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= HUNT;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      good_cnt_q    <= 4'd0;
      miss_cnt_q    <= 2'd0;
      wd_q          <= '0;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      good_cnt_q    <= good_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      wd_q          <= wd_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign video_on    = video_on_q;
  assign locked      = (state_q == LOCKED);
  assign frame_start = frame_start_q;
  assign sync_err    = sync_err_q;

endmodule
